// File: rtl/seg_display_mux_if.sv
// Host-side bundle for the multiplexed 7-segment driver.
// Carries the capture strobe and value/mode inputs, and the busy flag and scan lines back.
interface seg_display_mux_if #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 4
) ();
    logic [DATA_W-1:0]     value;
    logic                  load;
    logic [1:0]            mode;
    logic                  busy;
    logic [NUM_DIGITS-1:0] digit;
    logic [7:0]            segments;

    modport master (output value, load, mode, input busy, digit, segments);
    modport slave  (input value, load, mode, output busy, digit, segments);
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed common-anode 7-segment driver: captures a value, converts it to hex or
// (signed) decimal via sequential double-dabble, and time-multiplexes the digits.
module seg_display_mux #(
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4,
    parameter int BLANK_LZ    = 1
) (
    input  logic             sys_clk,
    input  logic             reset,
    seg_display_mux_if.slave bus
);
    // NBCD always covers the hex nibble count too, so one work buffer serves both modes.
    localparam int NBCD = (DATA_W * 3) / 10 + 1;
    localparam int NT   = (NBCD > NUM_DIGITS) ? NBCD : NUM_DIGITS;
    localparam int CW   = $clog2(DATA_W);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       busy, start, use_load, shift_en, commit;
    logic                       pend_vld_q;
    logic [DATA_W-1:0]          pend_val_q;
    logic [1:0]                 pend_mode_q;
    logic [DATA_W-1:0]          bin_q;
    logic [NBCD*4-1:0]          bcd_q;
    logic [CW-1:0]              cnt_q;
    logic                       hex_q, neg_q;
    logic                       last_shift;
    logic [DATA_W-1:0]          src_val, src_mag;
    logic [1:0]                 src_mode;
    logic                       src_neg;
    logic [NBCD*4-1:0]          bcd_adj;
    logic [NBCD*4+DATA_W-1:0]   shifted;
    logic [NT*4-1:0]            src_pad;
    int                         sig, lim;
    logic                       ovf;
    logic [NUM_DIGITS-1:0][7:0] disp_q, disp_d;
    logic [RW-1:0]              ref_q;
    logic                       ref_wrap;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS-1:0]      digit_q;
    logic [7:0]                 seg_q;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    assign last_shift = (cnt_q == CW'(DATA_W - 1));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.load) state_d = S_CONV;
            S_CONV:  if (hex_q || last_shift) state_d = S_DONE;
            S_DONE:  state_d = (pend_vld_q || bus.load) ? S_CONV : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A load arriving in DONE is taken directly; it supersedes whatever is pending.
    always_comb begin
        busy     = 1'b0;
        start    = 1'b0;
        use_load = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                start    = bus.load;
                use_load = 1'b1;
            end
            S_CONV: begin
                busy     = 1'b1;
                shift_en = !hex_q;
            end
            S_DONE: begin
                busy     = 1'b1;
                commit   = 1'b1;
                start    = pend_vld_q || bus.load;
                use_load = bus.load;
            end
            default: ;
        endcase
    end

    assign src_val  = use_load ? bus.value : pend_val_q;
    assign src_mode = use_load ? bus.mode  : pend_mode_q;
    assign src_neg  = (src_mode == 2'b01) && src_val[DATA_W-1];
    assign src_mag  = src_neg ? (DATA_W'(0) - src_val) : src_val;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NBCD; i++)
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            hex_q       <= 1'b0;
            neg_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_val_q  <= '0;
            pend_mode_q <= '0;
            disp_q      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            if (start) begin
                bin_q <= src_mag;
                bcd_q <= '0;
                cnt_q <= '0;
                hex_q <= src_mode[1];
                neg_q <= src_neg;
            end else if (shift_en) begin
                {bcd_q, bin_q} <= shifted;
                cnt_q          <= cnt_q + CW'(1);
            end
            if (start) begin
                pend_vld_q <= 1'b0;
            end else if (bus.load && busy) begin
                pend_vld_q  <= 1'b1;
                pend_val_q  <= bus.value;
                pend_mode_q <= bus.mode;
            end
            if (commit) disp_q <= disp_d;
        end
    end

    // Formatting reads the finished conversion; hex mode leaves bin_q unshifted.
    always_comb begin
        src_pad = '0;
        if (hex_q) src_pad[DATA_W-1:0] = bin_q;
        else       src_pad[NBCD*4-1:0] = bcd_q;
        sig = 1;
        for (int i = 0; i < NT; i++)
            if (src_pad[i*4 +: 4] != 4'd0) sig = i + 1;
        lim = neg_q ? NUM_DIGITS - 1 : NUM_DIGITS;
        ovf = (sig > lim);
        disp_d = {NUM_DIGITS{SEG_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf || (neg_q && i == NUM_DIGITS - 1)) disp_d[i] = SEG_MINUS;
            else if (BLANK_LZ != 0 && i >= sig)        disp_d[i] = SEG_BLANK;
            else                                       disp_d[i] = glyph(src_pad[i*4 +: 4]);
        end
    end

    assign ref_wrap = (ref_q == RW'(REFRESH_DIV - 1));

    always_comb begin
        idx_d = idx_q;
        if (ref_wrap) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // Anode and segment registers load from the same index so they never disagree.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ref_q   <= '0;
            idx_q   <= '0;
            digit_q <= ~NUM_DIGITS'(1);
            seg_q   <= SEG_BLANK;
        end else begin
            ref_q   <= ref_wrap ? '0 : ref_q + RW'(1);
            idx_q   <= idx_d;
            digit_q <= ~(NUM_DIGITS'(1) << idx_d);
            seg_q   <= disp_q[idx_d];
        end
    end

    assign bus.busy     = busy;
    assign bus.digit    = digit_q;
    assign bus.segments = seg_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: directed loads with a scoreboard queue of expected display
// contents, drained by a monitor that reassembles the scanned digits after each conversion.
`timescale 1ns/1ps
module tb_seg_display_mux;
    logic gclk = 1'b0;
    logic rst  = 1'b1;
    logic rst16 = 1'b1;
    always #5 gclk = ~gclk;

    seg_display_mux_if #(.DATA_W(8),  .NUM_DIGITS(4)) b ();
    seg_display_mux_if #(.DATA_W(16), .NUM_DIGITS(4)) b16 ();

    seg_display_mux #(.DATA_W(8), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .sys_clk(gclk), .reset(rst), .bus(b));
    seg_display_mux #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut16 (
        .sys_clk(gclk), .reset(rst16), .bus(b16));

    int checks = 0;
    int errors = 0;
    logic [31:0] expq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int dig_idx(input logic [3:0] d);
        int r = -1;
        for (int i = 0; i < 4; i++) if (!d[i]) r = i;
        return r;
    endfunction

    task automatic do_load(input logic [7:0] v, input logic [1:0] m);
        @(negedge gclk);
        b.value = v;
        b.mode  = m;
        b.load  = 1'b1;
        @(posedge gclk);
        #1 b.load = 1'b0;
    endtask

    task automatic run_conv(input logic [7:0] v, input logic [1:0] m, input logic [31:0] exp,
                            input int bexp, input string name);
        int hi;
        bit fell;
        int id;
        logic [7:0] lat_exp;
        do_load(v, m);
        expq.push_back(exp);
        hi = 0;
        fell = 0;
        for (int k = 0; k < 60 && !fell; k++) begin
            @(negedge gclk);
            if (b.busy) hi++;
            else fell = 1;
        end
        chk({name, "_busy_cycles"}, hi, bexp);
        @(posedge gclk);
        #1;
        id = dig_idx(b.digit);
        lat_exp = 8'h00;
        if (id >= 0) lat_exp = exp[id*8 +: 8];
        chk({name, "_latency"}, b.segments, lat_exp);
        repeat (20) @(negedge gclk);
    endtask

    // Monitor: after each busy fall, collect one full scan and compare with the queue head.
    initial begin : monitor
        logic prev;
        logic [31:0] got;
        int id;
        prev = 1'b0;
        forever begin
            @(negedge gclk);
            if (!rst && prev && !b.busy) begin
                @(posedge gclk);
                got = '1;
                for (int j = 0; j < 16; j++) begin
                    @(negedge gclk);
                    id = dig_idx(b.digit);
                    if (id >= 0) got[id*8 +: 8] = b.segments;
                end
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got %h expected no update", got);
                end else begin
                    chk("display", got, expq.pop_front());
                end
            end
            prev = b.busy;
        end
    end

    always @(negedge gclk) begin
        if (!rst) chk("onehot_anode", $countones(~b.digit), 1);
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int hi;
        bit fell;
        int id;
        int bad;
        logic [3:0] ed;
        logic [31:0] e200;
        logic [7:0] lat_exp;
        b.value = '0;  b.mode = '0;  b.load = 1'b0;
        b16.value = '0; b16.mode = '0; b16.load = 1'b0;
        repeat (3) @(negedge gclk);
        chk("rst_busy", b.busy, 0);
        chk("rst_digit", b.digit, 4'b1110);
        chk("rst_seg", b.segments, 8'hFF);
        rst = 1'b0;
        rst16 = 1'b0;
        #1;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge gclk);
            ed = ~(4'b0001 << (j / 4));
            chk("scan_digit", b.digit, ed);
            chk("scan_seg", b.segments, 8'hFF);
        end

        run_conv(8'd123, 2'b00, 32'hFFF9A4B0, 9, "dec123");
        run_conv(8'hFF,  2'b01, 32'hBFFFFFF9, 9, "sneg1");
        run_conv(8'hFF,  2'b00, 32'hFFA49292, 9, "dec255");
        run_conv(8'hA5,  2'b10, 32'hFFFF8892, 2, "hexA5");
        run_conv(8'd0,   2'b00, 32'hFFFFFFC0, 9, "zero");
        run_conv(8'h80,  2'b01, 32'hBFF9A480, 9, "sneg128");
        run_conv(8'h80,  2'b11, 32'hFFFF80C0, 2, "hex80");
        run_conv(8'h9C,  2'b01, 32'hBFF9C0C0, 9, "sneg100");
        run_conv(8'd127, 2'b01, 32'hFFF9A4F8, 9, "spos127");

        // 200, then 45 and 7 while busy: 45 is overwritten, 7 follows 200 back-to-back.
        e200 = 32'hFFA4C0C0;
        do_load(8'd200, 2'b00);
        expq.push_back(32'hFFFFFFF8);
        hi = 0;
        fell = 0;
        for (int k = 0; k < 60 && !fell; k++) begin
            @(negedge gclk);
            if (b.busy) hi++;
            else fell = 1;
            b.load  = (k == 2) || (k == 4);
            b.value = (k == 2) ? 8'd45 : 8'd7;
            if (k == 11) begin
                id = dig_idx(b.digit);
                lat_exp = 8'h00;
                if (id >= 0) lat_exp = e200[id*8 +: 8];
                chk("pend_first_shown", b.segments, lat_exp);
            end
        end
        b.load = 1'b0;
        chk("pend_busy_cycles", hi, 18);
        repeat (20) @(negedge gclk);

        @(negedge gclk);
        b16.value = 16'd12345;
        b16.mode  = 2'b00;
        b16.load  = 1'b1;
        @(posedge gclk);
        #1 b16.load = 1'b0;
        hi = 0;
        fell = 0;
        for (int k = 0; k < 60 && !fell; k++) begin
            @(negedge gclk);
            if (b16.busy) hi++;
            else fell = 1;
        end
        chk("w16_busy_cycles", hi, 17);
        @(posedge gclk);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge gclk);
            if (b16.segments != 8'hBF) bad++;
        end
        chk("w16_overflow_minus", bad, 0);

        @(negedge gclk);
        b16.value = 16'd999;
        b16.load  = 1'b1;
        @(posedge gclk);
        #1 b16.load = 1'b0;
        repeat (5) @(negedge gclk);
        chk("w16_busy_mid", b16.busy, 1);
        rst16 = 1'b1;
        #1;
        chk("w16_rst_busy", b16.busy, 0);
        chk("w16_rst_seg", b16.segments, 8'hFF);
        chk("w16_rst_digit", b16.digit, 4'b1110);
        @(negedge gclk);
        rst16 = 1'b0;

        for (int k = 0; k < 200 && expq.size() != 0; k++) @(negedge gclk);
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
